// File: rtl/instr_encoder_pkg.sv
// Shared opcodes, format codes, FSM states and the captured-request struct for the RV32I encoder.
// The optional immediate range check (INSTR_ENCODER_IMM_CHECK_EN) uses fits_signed().
package instr_encoder_pkg;

   localparam logic [6:0] R_TYPE  = 7'h33;
   localparam logic [6:0] I_LOGIC = 7'h13;
   localparam logic [6:0] I_LOAD  = 7'h03;
   localparam logic [6:0] I_JUMP  = 7'h67;
   localparam logic [6:0] U_TYPE  = 7'h37;
   localparam logic [6:0] S_TYPE  = 7'h23;
   localparam logic [6:0] B_TYPE  = 7'h63;
   localparam logic [6:0] J_TYPE  = 7'h6F;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I_LOGIC = 3'd1,
      FMT_I_LOAD  = 3'd2,
      FMT_I_JUMP  = 3'd3,
      FMT_U       = 3'd4,
      FMT_S       = 3'd5,
      FMT_B       = 3'd6,
      FMT_J       = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_WRITE  = 2'd2
   } state_e;

   typedef struct packed {
      fmt_e        fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } fields_t;

   // True when v sign-extends cleanly from its low 'bits' bits.
   function automatic logic fits_signed(input logic [31:0] v, input int bits);
      logic signed [31:0] t;
      t = $signed(v) >>> (bits - 1);
      return (t == 32'sd0) || (t == -32'sd1);
   endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational RV32I packer: format + fields -> 32-bit instruction word.
// With INSTR_ENCODER_IMM_CHECK_EN defined it also flags out-of-range immediates.
module instr_field_pack
   import instr_encoder_pkg::*;
(
   input  fields_t     fields_i,
   output logic [31:0] word_o,
   output logic        range_err_o
);

   logic [31:0] imm;
   assign imm = fields_i.imm;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      word_o = '0;
      case (fields_i.fmt)
         FMT_R:       word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3, fields_i.rd, R_TYPE};
         FMT_I_LOGIC: word_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, I_LOGIC};
         FMT_I_LOAD:  word_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, I_LOAD};
         FMT_I_JUMP:  word_o = {imm[11:0], fields_i.rs1, 3'b000, fields_i.rd, I_JUMP};
         FMT_U:       word_o = {imm[31:12], fields_i.rd, U_TYPE};
         FMT_S:       word_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], S_TYPE};
         FMT_B:       word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                                imm[4:1], imm[11], B_TYPE};
         FMT_J:       word_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, J_TYPE};
         default:     word_o = '0;
      endcase
   end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   always_comb begin
      range_err_o = 1'b0;
      case (fields_i.fmt)
         FMT_I_LOGIC, FMT_I_LOAD, FMT_I_JUMP, FMT_S:
                  range_err_o = !fits_signed(imm, 12);
         FMT_B:   range_err_o = !fits_signed(imm, 13) || imm[0];
         FMT_J:   range_err_o = !fits_signed(imm, 21) || imm[0];
         FMT_U:   range_err_o = (imm[11:0] != 12'd0);
         default: range_err_o = 1'b0;
      endcase
   end
`else
   assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field requests, packs them and writes words sequentially.
// Error_o can only be set when INSTR_ENCODER_IMM_CHECK_EN is defined; otherwise it stays 0.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start_i,
   input  logic                  Valid_i,
   output logic                  Ready_o,
   input  logic [2:0]            Fmt_i,
   input  logic [4:0]            Rd_i,
   input  logic [4:0]            Rs1_i,
   input  logic [4:0]            Rs2_i,
   input  logic [2:0]            Funct3_i,
   input  logic [6:0]            Funct7_i,
   input  logic [31:0]           Imm_i,
   output logic                  Mem_Write_o,
   output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
   output logic [31:0]           Mem_Data_o,
   output logic [ADDR_WIDTH:0]   Count_o,
   output logic                  Full_o,
   output logic                  Error_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   state_e                state_q;
   fields_t               fields_d, fields_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [ADDR_WIDTH:0]   count_d, count_q;
   logic [31:0]           data_q, packed_word;
   logic                  write_q, err_q, range_err;

   always_comb begin
      fields_d.fmt    = fmt_e'(Fmt_i);
      fields_d.rd     = Rd_i;
      fields_d.rs1    = Rs1_i;
      fields_d.rs2    = Rs2_i;
      fields_d.funct3 = Funct3_i;
      fields_d.funct7 = Funct7_i;
      fields_d.imm    = Imm_i;
   end

   instr_field_pack u_pack (
      .fields_i    (fields_q),
      .word_o      (packed_word),
      .range_err_o (range_err)
   );

   assign Full_o  = (count_q == DEPTH);
   assign Ready_o = (state_q == ST_IDLE) && !Full_o;
   assign addr_d  = addr_q + ADDR_WIDTH'(1);
   assign count_d = Full_o ? count_q : count_q + (ADDR_WIDTH+1)'(1);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         fields_q <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Start_i wins over a simultaneous request.
               if (Start_i) begin
                  addr_q  <= '0;
                  count_q <= '0;
                  err_q   <= 1'b0;
               end else if (Valid_i && Ready_o) begin
                  fields_q <= fields_d;
                  state_q  <= ST_ENCODE;
               end
            end
            ST_ENCODE: begin
               if (range_err) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  data_q  <= packed_word;
                  write_q <= 1'b1;
                  state_q <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               write_q <= 1'b0;
               addr_q  <= addr_d;
               count_q <= count_d;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Mem_Write_o = write_q;
   assign Mem_Addr_o  = addr_q;
   assign Mem_Data_o  = data_q;
   assign Count_o     = count_q;
   assign Error_o     = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the opcode decoder: packs instruction fields into 32-bit RV32I words and writes them sequentially into instruction memory.
- Used as a test-program builder or boot loader in front of the instruction ROM/RAM.
- Requests are accepted over a valid/ready handshake, encoded in one cycle, then written with a single-cycle write strobe.
- An internal word counter tracks the memory address.

Parameters:
- ADDR_WIDTH, 6, word-address width; capacity DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Start_i  input  1  synchronous restart; clears address and count
- Valid_i  input  1  request valid
- Ready_o  output  1  request can be accepted
- Fmt_i  input  3  0=R, 1=I_LOGIC, 2=I_LOAD, 3=I_JUMP, 4=U, 5=S, 6=B, 7=J
- Rd_i  input  5  destination register
- Rs1_i  input  5  source register 1
- Rs2_i  input  5  source register 2
- Funct3_i  input  3  funct3
- Funct7_i  input  7  funct7 (R only)
- Imm_i  input  32  immediate, byte offset for B/J
- Mem_Write_o  output  1  one-cycle write strobe
- Mem_Addr_o  output  ADDR_WIDTH  word address of the current write
- Mem_Data_o  output  32  encoded instruction
- Count_o  output  ADDR_WIDTH+1  number of words written
- Full_o  output  1  Count_o == DEPTH
- Error_o  output  1  sticky immediate-range error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state IDLE, Mem_Addr_o=0, Count_o=0, Mem_Data_o=0, Mem_Write_o=0, Error_o=0.
- States: IDLE -> ENCODE -> WRITE -> IDLE.
- IDLE:
  - Ready_o = !Full_o. Ready_o is 0 in every other state.
  - Handshake = Valid_i & Ready_o & !Start_i. On handshake, capture all fields and go to ENCODE.
- ENCODE: register the packed word into Mem_Data_o, then go to WRITE.
- WRITE:
  - Mem_Write_o=1 for exactly one cycle with the current Mem_Addr_o.
  - On exit, increment Mem_Addr_o (wraps to 0 at DEPTH) and Count_o, then return to IDLE.
- Latency: handshake at cycle N gives the write strobe at N+2. Maximum throughput is 1 word per 3 cycles.
- Packing (opcode in bits 6:0):
  - R: f7|rs2|rs1|f3|rd|0x33.
  - I_LOGIC: imm[11:0]|rs1|f3|rd|0x13.
  - I_LOAD: same fields, opcode 0x03.
  - I_JUMP: same fields, opcode 0x67, funct3 forced to 000.
  - U: imm[31:12]|rd|0x37.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|0x23.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|0x63.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|0x6F.
- Boundary conditions:
  - Full: Ready_o=0. Valid_i is ignored and must be held by the source.
  - Count_o saturates at DEPTH; Mem_Addr_o wraps to 0.
  - Start_i in IDLE clears Mem_Addr_o, Count_o and Error_o. Start_i has priority over a simultaneous Valid_i, and no handshake occurs.
  - Start_i in ENCODE or WRITE is ignored; the write in flight completes.
  - Reset mid-operation aborts the request: no strobe is issued and all outputs take their reset values.
  - Unused fields for a format are ignored.

Optional Feature:
- Macro: INSTR_ENCODER_IMM_CHECK_EN.
- Defined: the immediate is range-checked at ENCODE.
  - I/S: signed 12-bit.
  - B: signed 13-bit, even.
  - J: signed 21-bit, even.
  - U: imm[11:0] must be 0.
  - On violation: Error_o is set (sticky until Start_i or reset), WRITE is skipped, Count_o and Mem_Addr_o are unchanged, and the FSM returns to IDLE.
- Undefined: immediates are silently truncated and Error_o is tied to 0.

Decomposition:
- Shared package holds:
  - opcode constants R_TYPE=0x33, I_LOGIC=0x13, I_LOAD=0x03, I_JUMP=0x67, U_TYPE=0x37, S_TYPE=0x23, B_TYPE=0x63, J_TYPE=0x6F (reused by Control);
  - Fmt_i code constants;
  - FSM state encoding.
- Sub-module: instr_field_pack, purely combinational (fmt + fields -> 32-bit word, plus range-error flag). The top level holds the FSM, address and counter.

Test Plan:
- R add x3,x1,x2 (Fmt=0, Rd=3, Rs1=1, Rs2=2, f3=0, f7=0) -> two cycles after handshake Mem_Write_o=1, Mem_Addr_o=0, Mem_Data_o=0x002081B3, Count_o=1.
- Back-to-back addi x5,x0,-1 then sw x2,8(x1) -> 0xFFF00293 at addr 0, then 0x0020A423 at addr 1; Ready_o low for 2 cycles after each handshake.
- beq x0,x0,-4 (Imm=0xFFFFFFFC) -> 0xFE000EE3; jal x1,+8 -> 0x008000EF.
- ADDR_WIDTH=2, write 4 words -> Full_o=1, Ready_o=0, a held fifth Valid_i produces no strobe. Then Start_i -> Count_o=0, Mem_Addr_o=0, Ready_o=1 the next cycle.
- Reset asserted in ENCODE -> no Mem_Write_o pulse, all outputs at reset values immediately. Start_i together with Valid_i in IDLE -> no handshake.
- With INSTR_ENCODER_IMM_CHECK_EN, addi Imm=2048 -> Error_o=1, no strobe, Count_o unchanged. Without the macro -> word 0x80000013 (rd=0, rs1=0) is written.
